// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of instr_encoder.
// master = loader/sink side, slave = encoder side.
interface instr_encoder_if #(
   parameter int ADDR_W = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic [2:0]              kind;
   logic [2:0]              funct3;
   logic                    funct7b5;
   logic [4:0]              rd;
   logic [4:0]              rs1;
   logic [4:0]              rs2;
   logic signed [20:0]      imm;
   logic                    out_valid;
   logic                    out_ready;
   logic [31:0]             out_instr;
   logic [ADDR_W-1:0]       out_addr;

   modport master (
      output in_valid, kind, funct3, funct7b5, rd, rs1, rs2, imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr
   );

   modport slave (
      input  in_valid, kind, funct3, funct7b5, rd, rs1, rs2, imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words with auto-incrementing
// addresses. Optional immediate range checking is enabled by defining ENCO_RANGE_CHECK_EN.
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clear,
   instr_encoder_if.slave bus,
   output logic [15:0]    count,
   output logic           err
);
   localparam logic [2:0] K_LW  = 3'd0;
   localparam logic [2:0] K_SW  = 3'd1;
   localparam logic [2:0] K_R   = 3'd2;
   localparam logic [2:0] K_B   = 3'd3;
   localparam logic [2:0] K_I   = 3'd4;
   localparam logic [2:0] K_JAL = 3'd5;
   localparam logic [2:0] K_CSR = 3'd6;
   localparam logic [2:0] K_BAD = 3'd7;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_CSR = 7'b1110011;

   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   function automatic logic is_shift(input logic [2:0] f3);
      return (f3 == 3'b001) || (f3 == 3'b101);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   function automatic logic [31:0] encode(
      input logic [2:0]         k,
      input logic [2:0]         f3,
      input logic               f7b5,
      input logic [4:0]         rd_i,
      input logic [4:0]         rs1_i,
      input logic [4:0]         rs2_i,
      input logic signed [20:0] im
   );
      logic [31:0] w;
      w = '0;
      case (k)
         K_LW:  w = {im[11:0], rs1_i, 3'b010, rd_i, OP_LW};
         K_SW:  w = {im[11:5], rs2_i, rs1_i, 3'b010, im[4:0], OP_SW};
         K_R:   w = {1'b0, f7b5, 5'b00000, rs2_i, rs1_i, f3, rd_i, OP_R};
         K_B:   w = {im[12], im[10:5], rs2_i, rs1_i, f3, im[4:1], im[11], OP_B};
         K_I: begin
            if (is_shift(f3)) w = {1'b0, f7b5, 5'b00000, im[4:0], rs1_i, f3, rd_i, OP_I};
            else              w = {im[11:0], rs1_i, f3, rd_i, OP_I};
         end
         K_JAL: w = {im[20], im[10:1], im[11], im[19:12], rd_i, OP_JAL};
         K_CSR: w = {im[11:0], rs1_i, f3, rd_i, OP_CSR};
         default: w = '0;
      endcase
      return w;
   endfunction

`ifdef ENCO_RANGE_CHECK_EN
   function automatic logic imm_in_range(
      input logic [2:0]         k,
      input logic [2:0]         f3,
      input logic signed [20:0] im
   );
      logic ok;
      ok = 1'b1;
      case (k)
         K_LW, K_SW: ok = (im >= -21'sd2048) && (im <= 21'sd2047);
         K_B:        ok = (im >= -21'sd4096) && (im <= 21'sd4094) && !im[0];
         K_I: begin
            if (is_shift(f3)) ok = (im >= 21'sd0) && (im <= 21'sd31);
            else              ok = (im >= -21'sd2048) && (im <= 21'sd2047);
         end
         // The 21-bit input already spans the full JAL range; only alignment matters.
         K_JAL:      ok = !im[0];
         K_CSR:      ok = (im >= 21'sd0) && (im <= 21'sd4095);
         K_R:        ok = 1'b1;
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction
`endif

   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic [15:0]       count_q, count_d;
   logic              err_q, err_d;
   logic              accept;
   logic              out_fire;
   logic              legal;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign out_fire     = out_valid_q && bus.out_ready;

`ifdef ENCO_RANGE_CHECK_EN
   assign legal = (bus.kind != K_BAD) && imm_in_range(bus.kind, bus.funct3, bus.imm);
`else
   assign legal = (bus.kind != K_BAD);
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;
      addr_cnt_d  = addr_cnt_q;
      count_d     = count_q;
      err_d       = err_q;

      if (out_fire) begin
         out_valid_d = 1'b0;
         count_d     = sat_inc(count_q);
      end

      // Dropped bundles still consume their handshake but never touch the address counter.
      if (accept) begin
         if (legal) begin
            out_valid_d = 1'b1;
            out_instr_d = encode(bus.kind, bus.funct3, bus.funct7b5,
                                 bus.rd, bus.rs1, bus.rs2, bus.imm);
            out_addr_d  = addr_cnt_q;
            addr_cnt_d  = addr_cnt_q + ADDR_STEP;
         end else begin
            err_d = 1'b1;
         end
      end

      if (clear) begin
         out_valid_d = 1'b0;
         addr_cnt_d  = BASE_ADDR;
         count_d     = '0;
         err_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_addr_q  <= BASE_ADDR;
         addr_cnt_q  <= BASE_ADDR;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
         addr_cnt_q  <= addr_cnt_d;
         count_q     <= count_d;
         err_q       <= err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_addr  = out_addr_q;
   assign count         = count_q;
   assign err           = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors plus randomized bundles checked
// against an arithmetic encoding model; a small second instance checks address wrap.
`timescale 1ns/1ps
module tb_instr_encoder;
   localparam int            AW   = 32;
   localparam logic [AW-1:0] BASE = 32'h0000_0100;
`ifdef ENCO_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct packed {
      logic [31:0]   instr;
      logic [AW-1:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic [15:0] count;
   logic        err;
   logic        clear2;
   logic [15:0] count2;
   logic        err2;

   instr_encoder_if #(.ADDR_W(AW)) bus ();
   instr_encoder_if #(.ADDR_W(4))  bus2 ();

   instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .clear(clear), .bus(bus), .count(count), .err(err)
   );
   instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) dut2 (
      .clk(clk), .rst(rst), .clear(clear2), .bus(bus2), .count(count2), .err(err2)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad = 0;
   int            rdy_pct = 100;
   int            stalls = 0;
   exp_t          sbq[$];
   logic [3:0]    sbq2[$];
   logic [AW-1:0] m_addr;
   int            m_count;
   bit            m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_enc(input int k, input int f3, input int f7,
                                         input int rd, input int rs1, input int rs2, input int imm);
      logic [31:0] u, w, r, a, b, d;
      u = imm; r = rd; a = rs1; b = rs2; d = f3;
      case (k)
         0: w = ((u & 32'hFFF) << 20) | (a << 15) | (32'd2 << 12) | (r << 7) | 32'h03;
         1: w = (((u >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (32'd2 << 12)
                | ((u & 32'h1F) << 7) | 32'h23;
         2: w = ((f7 != 0) ? 32'h4000_0000 : 32'h0) | (b << 20) | (a << 15) | (d << 12)
                | (r << 7) | 32'h33;
         3: w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (b << 20)
                | (a << 15) | (d << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7)
                | 32'h63;
         4: begin
            if (f3 == 1 || f3 == 5)
               w = ((f7 != 0) ? 32'h4000_0000 : 32'h0) | ((u & 32'h1F) << 20) | (a << 15)
                   | (d << 12) | (r << 7) | 32'h13;
            else
               w = ((u & 32'hFFF) << 20) | (a << 15) | (d << 12) | (r << 7) | 32'h13;
         end
         5: w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | (r << 7) | 32'h6F;
         6: w = ((u & 32'hFFF) << 20) | (a << 15) | (d << 12) | (r << 7) | 32'h73;
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   function automatic bit m_legal(input int k, input int f3, input int imm);
      case (k)
         0, 1: return imm >= -2048 && imm <= 2047;
         2:    return 1'b1;
         3:    return imm >= -4096 && imm <= 4094 && (imm % 2) == 0;
         4:    return (f3 == 1 || f3 == 5) ? (imm >= 0 && imm <= 31) : (imm >= -2048 && imm <= 2047);
         5:    return imm >= -1048576 && imm <= 1048574 && (imm % 2) == 0;
         6:    return imm >= 0 && imm <= 4095;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_accept(input int k, input int f3, input int f7, input int rd, input int rs1,
                               input int rs2, input int imm, input bit has_exp, input logic [31:0] exp_w);
      exp_t e;
      if (k == 7 || (RC && !m_legal(k, f3, imm))) begin
         m_err = 1'b1;
      end else begin
         e.instr = has_exp ? exp_w : m_enc(k, f3, f7, rd, rs1, rs2, imm);
         e.addr  = m_addr;
         sbq.push_back(e);
         m_addr  = m_addr + 32'd4;
      end
   endtask

   function automatic logic pick_ready();
      return $urandom_range(0, 99) < rdy_pct;
   endfunction

   task automatic drive(input int k, input int f3, input int f7, input int rd, input int rs1,
                        input int rs2, input int imm);
      bus.in_valid = 1'b1;
      bus.kind     = 3'(k);
      bus.funct3   = 3'(f3);
      bus.funct7b5 = 1'(f7);
      bus.rd       = 5'(rd);
      bus.rs1      = 5'(rs1);
      bus.rs2      = 5'(rs2);
      bus.imm      = 21'(imm);
   endtask

   task automatic send(input int k, input int f3, input int f7, input int rd, input int rs1,
                       input int rs2, input int imm, input bit has_exp, input logic [31:0] exp_w);
      int waits = 0;
      @(negedge clk);
      drive(k, f3, f7, rd, rs1, rs2, imm);
      bus.out_ready = pick_ready();
      #3;
      while (!bus.in_ready && waits < 100) begin
         @(negedge clk);
         bus.out_ready = pick_ready();
         #3;
         waits++;
      end
      stalls += waits;
      if (!bus.in_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout: got in_ready=0 after %0d cycles expected 1", waits);
      end else begin
         model_accept(k, f3, f7, rd, rs1, rs2, imm, has_exp, exp_w);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid  = 1'b0;
         bus.out_ready = pick_ready();
      end
   endtask

   task automatic drain_and_check(input string tag);
      int n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(negedge clk);
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         n++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, "_drained"}, sbq.size(), 0);
      chk({tag, "_count"}, count, m_count);
      chk({tag, "_err"}, err, m_err);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst && !clear && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_word: got %08h expected no word", bus.out_instr);
            end else begin
               e = sbq.pop_front();
               chk("instr", bus.out_instr, e.instr);
               chk("addr", bus.out_addr, e.addr);
            end
            if (m_count < 65535) m_count++;
         end
      end
   end

   initial begin : monitor2
      logic [3:0] ea;
      forever begin
         @(negedge clk);
         #3;
         if (!rst && bus2.out_valid && bus2.out_ready) begin
            if (sbq2.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_wrap_word: got addr %0h expected no word", bus2.out_addr);
            end else begin
               ea = sbq2.pop_front();
               chk("wrap_addr", bus2.out_addr, ea);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int k, f3, imm, mode;
      exp_t ea;
      rst = 1'b1; clear = 1'b0; clear2 = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      bus.in_valid = 1'b0;
      bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.kind = 3'd4; bus2.funct3 = 3'd0;
      bus2.funct7b5 = 1'b0; bus2.rd = 5'd1; bus2.rs1 = 5'd0; bus2.rs2 = 5'd0; bus2.imm = 21'sd1;
      m_addr = BASE; m_count = 0; m_err = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_instr", bus.out_instr, 0);
      chk("rst_out_addr", bus.out_addr, BASE);
      chk("rst_count", count, 0);
      chk("rst_err", err, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_wrap_addr", bus2.out_addr, 4'd12);
      @(negedge clk);
      rst = 1'b0;

      // first word
      send(4, 0, 0, 1, 0, 0, 5, 1'b1, 32'h00500093);
      drain_and_check("first");

      // back-to-back directed stream
      stalls = 0;
      send(0, 0, 0, 2, 1, 0, 8, 1'b1, 32'h0080A103);
      send(1, 0, 0, 0, 1, 2, 4, 1'b1, 32'h0020A223);
      send(2, 0, 0, 3, 1, 2, 0, 1'b1, 32'h002081B3);
      send(2, 0, 1, 3, 1, 2, 0, 1'b1, 32'h402081B3);
      send(3, 0, 0, 0, 1, 2, -4, 1'b1, 32'hFE208EE3);
      send(5, 0, 0, 1, 0, 0, 8, 1'b1, 32'h008000EF);
      send(6, 1, 0, 5, 6, 0, 32'h300, 1'b1, 32'h300312F3);
      chk("throughput_stalls", stalls, 0);
      drain_and_check("stream");

      // backpressure
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(4, 0, 0, 7, 3, 0, -1);
      #3;
      chk("bp_first_accept", bus.in_ready, 1);
      model_accept(4, 0, 0, 7, 3, 0, -1, 1'b1, 32'hFFF18393);
      ea = sbq[sbq.size()-1];
      @(posedge clk);
      @(negedge clk);
      drive(2, 0, 1, 4, 5, 6, 0);
      repeat (3) begin
         #3;
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_instr_hold", bus.out_instr, ea.instr);
         chk("bp_addr_hold", bus.out_addr, ea.addr);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #3;
      chk("bp_second_accept", bus.in_ready, 1);
      model_accept(2, 0, 1, 4, 5, 6, 0, 1'b1, 32'h40628233);
      @(posedge clk);
      drain_and_check("bp");

      // illegal kind then legal word
      send(7, 0, 0, 1, 1, 1, 0, 1'b0, 32'h0);
      send(4, 0, 0, 9, 2, 0, 100, 1'b0, 32'h0);
      drain_and_check("illegal");
      chk("illegal_err_set", err, 1);

      // odd branch offset: dropped with range check, truncated without
      send(3, 0, 0, 0, 1, 2, 3, 1'b1, 32'h00208163);
      drain_and_check("b_odd");

      // clear over a stalled word, then over a simultaneous accept
      rdy_pct = 0;
      send(4, 0, 0, 10, 1, 0, 7, 1'b0, 32'h0);
      @(negedge clk);
      clear = 1'b1;
      bus.out_ready = 1'b0;
      drive(4, 0, 0, 11, 1, 0, 9);
      sbq.delete();
      m_addr = BASE; m_count = 0; m_err = 1'b0;
      @(negedge clk);
      #3;
      chk("clear_in_ready", bus.in_ready, 1);
      @(negedge clk);
      clear = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("clear_out_valid", bus.out_valid, 0);
      chk("clear_count", count, 0);
      chk("clear_err", err, 0);
      rdy_pct = 100;
      send(4, 0, 0, 12, 1, 0, 3, 1'b0, 32'h0);
      drain_and_check("after_clear");

      // randomized traffic with random backpressure
      rdy_pct = 60;
      for (int i = 0; i < 300; i++) begin
         k = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, 6));
         f3 = int'($urandom_range(0, 7));
         mode = int'($urandom_range(0, 3));
         case (mode)
            0: imm = int'($urandom_range(0, 4095)) - 2048;
            1: imm = int'($urandom_range(0, 40));
            2: imm = int'($urandom_range(0, 2097151)) - 1048576;
            default: imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
         endcase
         send(k, f3, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm, 1'b0, 32'h0);
         if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      end
      drain_and_check("random");

      // asynchronous reset with a word pending
      rdy_pct = 0;
      send(4, 0, 0, 13, 1, 0, 1, 1'b0, 32'h0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_instr", bus.out_instr, 0);
      chk("arst_out_addr", bus.out_addr, BASE);
      chk("arst_count", count, 0);
      chk("arst_err", err, 0);
      sbq.delete();
      m_addr = BASE; m_count = 0; m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      rdy_pct = 100;
      send(4, 0, 0, 14, 1, 0, 2, 1'b0, 32'h0);
      drain_and_check("after_arst");

      // address wrap on the 4-bit instance
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus2.in_valid = 1'b1;
         bus2.rd = 5'(i + 1);
         sbq2.push_back(4'((12 + 4 * i) % 16));
         @(posedge clk);
      end
      @(negedge clk);
      bus2.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("wrap_drained", sbq2.size(), 0);
      chk("wrap_count", count2, 4);
      chk("wrap_err", err2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential RV32I instruction encoder, the inverse of the control-path opcode decoder. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words. Each word is emitted with an auto-incrementing instruction-memory address. Used by the boot/test loader to fill instruction memory; covers the same classes the decoder supports (LW, SW, R, B, I, JAL, CSR).

Parameters:
ADDR_W, 32, width of out_addr and the internal address counter
BASE_ADDR, 0, address loaded on reset and on clear; must be a multiple of 4

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
clear  input  1  synchronous: addr counter := BASE_ADDR, drop out_valid, zero count
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept bundle
kind  input  3  0=LW 1=SW 2=R 3=B 4=I 5=JAL 6=CSR 7=illegal
funct3  input  3  funct3 (ignored for LW/SW/JAL; forced 010 for LW/SW)
funct7b5  input  1  bit 30 for R-type and I-type shifts (funct3 001/101)
rd  input  5  destination register
rs1  input  5  source 1
rs2  input  5  source 2
imm  input  21  signed immediate; for CSR, imm[11:0] is the CSR address
out_valid  output  1  out_instr/out_addr valid
out_ready  input  1  sink accepts word
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  byte address of out_instr
count  output  16  words emitted since reset/clear, saturating at 0xFFFF
err  output  1  sticky: set on any dropped bundle, cleared only by rst/clear

Behaviour:
- Reset (async): out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0, err=0; internal addr counter=BASE_ADDR.
- Single output register, latency 1 cycle: bundle accepted at edge N appears on out_valid after edge N.
- in_ready = !out_valid || out_ready (combinational); full throughput of 1 word/cycle under continuous out_ready.
- Input accept = in_valid && in_ready; output handshake = out_valid && out_ready.
- out_instr, out_addr hold stable while out_valid && !out_ready.
- Address: a legal bundle accepted loads out_addr from the counter; the counter then += 4, wrapping modulo 2^ADDR_W. Counter advances at accept, not at output handshake.
- count += 1 on each output handshake; saturates.
- Opcodes: LW 0000011, SW 0100011, R 0110011, B 1100011, I 0010011, JAL 1101111, CSR 1110011.
- Encodings:
  - I/LW: {imm[11:0],rs1,f3,rd,op}; I with f3 001/101 puts funct7b5 in bit 30, shamt=imm[4:0], bits 31,29:25 zero.
  - SW: {imm[11:5],rs2,rs1,010,imm[4:0],op}.
  - R: {0,funct7b5,00000,rs2,rs1,f3,rd,op}.
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - CSR: {imm[11:0],rs1,f3,rd,op}.
- Fields outside each format are ignored.
- kind=7: bundle is accepted (consumes handshake), produces no output, does not advance the counter, sets err.
- clear has priority over a simultaneous accept; that bundle is discarded.
- clear while out_valid && !out_ready: the word is dropped, with no handshake.
- rst mid-stream: pending word is lost, all state returns to its reset value immediately.

Optional Feature:
ENCO_RANGE_CHECK_EN: when defined, immediates are range-checked. Legal ranges:
- I/LW/SW: -2048..2047
- B: -4096..4094, even
- JAL: -1048576..1048574, even
- I-shift: 0..31
- CSR: 0..4095

An out-of-range bundle is handled like kind=7: accepted, dropped, err set, counter unchanged. When not defined, no check is made; the immediate is silently truncated to its format bits and the word is emitted.

Test Plan:
- Reset, then I: rd=1, rs1=0, f3=000, imm=5 with out_ready=1 -> next cycle out_instr=0x00500093, out_addr=BASE_ADDR, count=1.
- Back-to-back stream, out_ready=1: LW rd=2 rs1=1 imm=8; SW rs2=2 rs1=1 imm=4; R add rd=3 rs1=1 rs2=2; R with funct7b5=1 -> 0x0080A103, 0x0020A223, 0x002081B3, 0x402081B3 on consecutive cycles, addrs +0,+4,+8,+12.
- B f3=000 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3. JAL rd=1 imm=8 -> 0x008000EF. CSR f3=001 rd=5 rs1=6 imm=0x300 -> 0x300312F3.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept, out_instr/out_addr stable, no second word lost or duplicated.
- kind=7, then a legal I bundle -> err=1, the legal word gets the address the illegal one would have taken. Then clear -> err=0, count=0, next out_addr=BASE_ADDR.
- With ENCO_RANGE_CHECK_EN, B imm=3 -> dropped, err=1. Without it -> word emitted with imm[0] discarded.
- Address wrap with ADDR_W=4, BASE_ADDR=12 -> out_addr sequence 12, 0, 4.
